// File: rtl/ifetch_unit.sv
// ifetch_unit: multi-cycle instruction fetch stage.
// Owns the architectural PC. For each instruction it issues one memory read,
// captures the returned word and offers it to decode with a valid/ready
// handshake. On acceptance the PC is reloaded from the next-PC stage. A
// misaligned next PC parks the unit in a terminal fault state until reset.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,

    // next-PC loop
    input  logic [31:0] npc_i,
    output logic [31:0] pc_o,

    // instruction memory request/response
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,

    // decode handshake
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,

    // status
    output logic        fault_o,
    output logic [31:0] retire_cnt_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retire_cnt;
    logic        fault;

    // Only word-aligned next PCs are legal; anything else is a fault.
    logic        npc_misaligned;
    assign npc_misaligned = (npc_i[1:0] != 2'b00);

    // Fetch sequencing, PC update, instruction capture and retire counting.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= 32'h0000_0000;
            retire_cnt <= 32'h0000_0000;
            fault      <= 1'b0;
        end else begin
            case (state)
                // One dead cycle after reset so the first request starts cleanly.
                IDLE: begin
                    state <= REQ;
                end

                // Request stays asserted on the current PC until memory takes it.
                // Any response seen here is stale and is dropped.
                REQ: begin
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end

                // Wait indefinitely for the read data of the accepted request.
                WAIT: begin
                    if (imem_rsp_valid) begin
                        instr <= imem_rsp_data;
                        state <= HOLD;
                    end
                end

                // Instruction offered to decode; PC and word frozen until taken.
                HOLD: begin
                    if (if_ready) begin
                        retire_cnt <= retire_cnt + 32'd1;
                        if (npc_misaligned) begin
                            fault <= 1'b1;
                            state <= FAULT;
                        end else begin
                            pc    <= npc_i;
                            state <= REQ;
                        end
                    end
                end

                // Terminal: only reset leaves this state.
                FAULT: begin
                    fault <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs depend only on the registered state.
    assign imem_req_valid = (state == REQ);
    assign if_valid       = (state == HOLD);

    assign pc_o          = pc;
    assign imem_req_addr = pc;
    assign if_pc         = pc;
    assign if_instr      = instr;
    assign fault_o       = fault;
    assign retire_cnt_o  = retire_cnt;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit.
// Each accepted memory request pushes the expected {pc, instr} pair; each
// decode handshake pops and compares it.
module tb_ifetch_unit;

    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        rstn;
    logic [31:0] npc_i;
    logic [31:0] pc_o;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        fault_o;
    logic [31:0] retire_cnt_o;

    ifetch_unit #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .npc_i          (npc_i),
        .pc_o           (pc_o),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .fault_o        (fault_o),
        .retire_cnt_o   (retire_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_retire;
    logic        exp_fault;
    int          last_accept;

    // advance one clock; sample #1 after the edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // one complete instruction, starting with the DUT in REQ
    task automatic run_instr(input logic [31:0] data, input logic [31:0] npc,
                             input int req_stall, input int rsp_delay,
                             input int hold_stall, input bit noise);
        logic [63:0] e;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_issue valid=%b addr=%h expected valid=1 addr=%h", imem_req_valid, imem_req_addr, exp_pc);
        end
        for (int i = 0; i < req_stall; i++) begin
            imem_req_ready = 1'b0;
            if (noise) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end
            step();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc || if_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_hold valid=%b addr=%h if_valid=%b expected 1 %h 0", imem_req_valid, imem_req_addr, if_valid, exp_pc);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        sb.push_back({exp_pc, data});
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_quiet req_valid=%b if_valid=%b expected 0 0", imem_req_valid, if_valid);
        end
        for (int i = 0; i < rsp_delay; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait_stay if_valid=%b req_valid=%b expected 0 0", if_valid, imem_req_valid);
            end
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < hold_stall; i++) begin
            npc_i = $urandom;
            if (noise) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = $urandom;
            end
            step();
            checks++;
            if (if_valid !== 1'b1 || if_instr !== data || if_pc !== exp_pc || pc_o !== exp_pc) begin
                errors++;
                $display("FAIL hold_stable valid=%b instr=%h pc=%h expected 1 %h %h", if_valid, if_instr, if_pc, data, exp_pc);
            end
        end
        imem_rsp_valid = 1'b0;
        if_ready = 1'b1;
        npc_i    = npc;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty got handshake with no expected entry, required one entry");
        end else begin
            e = sb.pop_front();
            if (if_valid !== 1'b1 || {if_pc, if_instr} !== e) begin
                errors++;
                $display("FAIL sb_pair valid=%b pc=%h instr=%h expected 1 %h %h", if_valid, if_pc, if_instr, e[63:32], e[31:0]);
            end
        end
        last_accept = cycle;
        step();
        if_ready = 1'b0;
        exp_retire = exp_retire + 32'd1;
        if (npc[1:0] == 2'b00) exp_pc = npc;
        else                   exp_fault = 1'b1;
        checks++;
        if (retire_cnt_o !== exp_retire || fault_o !== exp_fault || pc_o !== exp_pc || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_accept cnt=%0d fault=%b pc=%h if_valid=%b expected %0d %b %h 0", retire_cnt_o, fault_o, pc_o, if_valid, exp_retire, exp_fault, exp_pc);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; npc_i = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; if_ready = 1'b0;
        step();
        step();
        exp_pc = RPC; exp_retire = '0; exp_fault = 1'b0; sb.delete();
        checks++;
        if (pc_o !== RPC || if_instr !== 32'h0 || retire_cnt_o !== 32'h0 || fault_o !== 1'b0 ||
            imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h instr=%h cnt=%0d fault=%b rv=%b iv=%b expected %h 0 0 0 0 0",
                     pc_o, if_instr, retire_cnt_o, fault_o, imem_req_valid, if_valid, RPC);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            errors++;
            $display("FAIL first_req valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RPC);
        end
    endtask

    task automatic test_zero_wait;
        int prev;
        run_instr(32'h2008_0005, exp_pc + 32'd4, 0, 0, 0, 1'b0);
        prev = last_accept;
        for (int k = 0; k < 2; k++) begin
            run_instr(32'h2008_0005, exp_pc + 32'd4, 0, 0, 0, 1'b0);
            checks++;
            if (last_accept - prev !== 3) begin
                errors++;
                $display("FAIL throughput gap=%0d cycles expected 3", last_accept - prev);
            end
            prev = last_accept;
        end
        checks++;
        if (retire_cnt_o !== 32'd3 || pc_o !== RPC + 32'd12) begin
            errors++;
            $display("FAIL zero_wait_end cnt=%0d pc=%h expected 3 %h", retire_cnt_o, pc_o, RPC + 32'd12);
        end
    endtask

    task automatic test_backpressure;
        run_instr(32'h1234_5678, exp_pc + 32'd4, 4, 2, 5, 1'b1);
        run_instr(32'hA5A5_0F0F, exp_pc + 32'd4, 1, 3, 2, 1'b1);
    endtask

    task automatic test_jump;
        run_instr(32'h0800_0004, 32'h0040_0010, 0, 0, 1, 1'b0);
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0040_0010) begin
            errors++;
            $display("FAIL jump_target valid=%b addr=%h expected 1 00400010", imem_req_valid, imem_req_addr);
        end
        run_instr(32'h0000_0013, 32'h0000_3000, 0, 1, 0, 1'b0);
    endtask

    task automatic test_misaligned;
        logic [31:0] fpc;
        logic [31:0] cnt_before;
        fpc = exp_pc;
        cnt_before = exp_retire;
        run_instr(32'hFFFF_0001, 32'h0000_3006, 0, 1, 1, 1'b0);
        checks++;
        if (fault_o !== 1'b1 || pc_o !== fpc || retire_cnt_o !== cnt_before + 32'd1) begin
            errors++;
            $display("FAIL fault_entry fault=%b pc=%h cnt=%0d expected 1 %h %0d", fault_o, pc_o, retire_cnt_o, fpc, cnt_before + 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
            if_ready = 1'b1; npc_i = 32'h0000_4000;
            step();
            checks++;
            if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || fault_o !== 1'b1 || pc_o !== fpc ||
                retire_cnt_o !== cnt_before + 32'd1) begin
                errors++;
                $display("FAIL fault_terminal rv=%b iv=%b fault=%b pc=%h cnt=%0d expected 0 0 1 %h %0d",
                         imem_req_valid, if_valid, fault_o, pc_o, retire_cnt_o, fpc, cnt_before + 32'd1);
            end
        end
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; if_ready = 1'b0;
        rstn = 1'b0;
        step();
        checks++;
        if (fault_o !== 1'b0 || pc_o !== RPC || retire_cnt_o !== 32'h0 || if_instr !== 32'h0 ||
            imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_reset fault=%b pc=%h cnt=%0d instr=%h rv=%b iv=%b expected 0 %h 0 0 0 0",
                     fault_o, pc_o, retire_cnt_o, if_instr, imem_req_valid, if_valid, RPC);
        end
        exp_pc = RPC; exp_retire = '0; exp_fault = 1'b0; sb.delete();
    endtask

    task automatic test_reset_in_wait;
        rstn = 1'b1;
        step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        checks++;
        if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle iv=%b rv=%b expected 0 0", if_valid, imem_req_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RPC || if_instr !== 32'h0) begin
                errors++;
                $display("FAIL rst_wait_stale iv=%b rv=%b addr=%h instr=%h expected 0 1 %h 0",
                         if_valid, imem_req_valid, imem_req_addr, if_instr, RPC);
            end
        end
        imem_rsp_valid = 1'b0;
        exp_pc = RPC; exp_retire = '0; exp_fault = 1'b0; sb.delete();
        run_instr(32'h0C0F_FEE0, RPC + 32'd4, 0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_jump();
        test_misaligned();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Multi-cycle instruction fetch stage that owns the architectural PC register.
- Issues one instruction-memory read per instruction and presents the fetched word to decode with a valid/ready handshake.
- On decode acceptance, loads the next PC from the next-PC stage (npc_i).
- pc_o drives the next-PC stage's PC input, closing the PC → next-PC → PC loop.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rstn  input  1  synchronous active-low reset.
- npc_i  input  32  next PC from next-PC stage, sampled only on decode accept.
- pc_o  output  32  current PC register.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch address, equals pc_o.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  read data valid.
- imem_rsp_data  input  32  read data.
- if_valid  output  1  instruction available to decode.
- if_instr  output  32  registered instruction word.
- if_pc  output  32  PC of if_instr, equals pc_o.
- if_ready  input  1  decode accepts instruction.
- fault_o  output  1  sticky misaligned-next-PC fault.
- retire_cnt_o  output  32  count of instructions accepted by decode.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset (rstn=0 at edge):
  - state=IDLE, pc_o=RESET_PC, if_instr=0, retire_cnt_o=0, fault_o=0.
  - imem_req_valid=0 and if_valid=0, since both decode from state.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT. Outputs are decoded from state only; no combinational input-to-output paths.
- IDLE:
  - All valids 0.
  - Unconditionally → REQ next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc_o, held stable until the handshake.
  - On imem_req_valid & imem_req_ready → WAIT.
  - imem_rsp_valid is ignored in REQ. Responses arrive ≥1 cycle after request acceptance, and stale responses after reset are dropped.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: if_instr<=imem_rsp_data → HOLD. Otherwise stay, with no timeout.
- HOLD:
  - if_valid=1. if_instr and if_pc are stable until accepted.
  - On if_ready, retire_cnt_o<=retire_cnt_o+1, wrapping from 32'hFFFF_FFFF to 0. Then:
    - if npc_i[1:0]==0: pc_o<=npc_i → REQ.
    - else: pc_o unchanged, fault_o<=1 → FAULT. The count still increments.
  - Without if_ready: stay; npc_i is ignored.
  - imem_rsp_valid is ignored in HOLD and FAULT.
- FAULT:
  - All valids 0, fault_o=1.
  - Terminal until rstn=0.
- Throughput: best case 3 cycles per instruction (REQ, WAIT, HOLD) when ready/rsp arrive immediately.
- Reset mid-operation: rstn=0 in any state overrides all other inputs at that edge. An in-flight response arriving afterwards is discarded (state is IDLE/REQ).
- Simultaneous events: in HOLD, if_ready with a misaligned npc_i takes the fault path; there is no partial PC update.
- Arithmetic: pc_o is fully loaded from npc_i. There is no internal increment; the next-PC stage owns +4, branch and jump.

Test Plan:
- Reset release with RESET_PC=32'h0000_3000 → cycle 1 IDLE (req_valid=0); cycle 2 imem_req_valid=1, imem_req_addr=32'h0000_3000.
- Zero-wait memory returning 32'h2008_0005 one cycle after acceptance; if_ready tied 1; npc_i=pc_o+4 → if_valid pulses every 3rd cycle; PCs 3000, 3004, 3008; retire_cnt_o=3 after 3 instructions.
- Backpressure: hold imem_req_ready=0 for 4 cycles, then if_ready=0 for 5 cycles → imem_req_addr stable throughout; if_instr/if_pc unchanged while in HOLD; npc_i changes during HOLD are ignored.
- Jump: in HOLD, npc_i=32'h0040_0010 with if_ready=1 → next request addr 32'h0040_0010.
- Misaligned: npc_i=32'h0000_3006 on accept → fault_o=1; no further requests; pc_o stays at the faulting instruction's PC; retire_cnt_o incremented; rstn=0 clears everything.
- Reset in WAIT, then imem_rsp_valid=1 arrives in IDLE/REQ → response ignored; if_valid stays 0; a fresh request is issued to RESET_PC.
